// File: rtl/phase2_pkg.sv
// Shared types and constants for the two-phase handshake transmitter.
package phase2_pkg;

  // Width of the completed-transfer counter.
  localparam int unsigned CNT_W = 16;

  // Transmit FSM: IDLE has no word in flight; WAIT_ACK waits for the remote toggle.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

endpackage

// File: rtl/phase2_sync.sv
// Single-bit multi-flop synchronizer. Brings an asynchronous level into the clk_i domain.
module phase2_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the async input through the flop chain; cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/phase2_tx.sv
// Two-phase (toggle) request/acknowledge transmitter with a small FIFO input buffer.
// Each toggle of req_o announces the word on data_o; the remote receiver answers by
// making ack_i equal to req_o. ack_i is asynchronous and is synchronized before use.
module phase2_tx
  import phase2_pkg::*;
#(
  parameter type T             = logic [31:0],
  parameter int  LOG_BUF_DEPTH = 1,
  parameter int  SYNC_STAGES   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  T                 in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             req_o,
  output T                 data_o,
  input  logic             ack_i,
  output logic             idle_o,
  output logic             err_o,
  output logic [CNT_W-1:0] tx_count_o
);

  localparam int unsigned DEPTH = 2 ** LOG_BUF_DEPTH;

  // Buffer storage and wrap-bit pointers.
  T                   r_mem [DEPTH];
  logic [LOG_BUF_DEPTH:0] r_wptr;
  logic [LOG_BUF_DEPTH:0] r_rptr;

  // Transmit side state.
  state_t             r_state;
  logic               r_req;
  T                   r_data;
  logic               r_err;
  logic [CNT_W-1:0]   r_count;

  // Combinational helpers.
  logic w_ack_s;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_done;

  phase2_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (ack_i),
    .q_o  (w_ack_s)
  );

  // Buffer status, handshake completion and push/pop qualification.
  always_comb begin
    w_full  = (r_wptr[LOG_BUF_DEPTH] != r_rptr[LOG_BUF_DEPTH]) &&
              (r_wptr[LOG_BUF_DEPTH-1:0] == r_rptr[LOG_BUF_DEPTH-1:0]);
    w_empty = (r_wptr == r_rptr);
    w_push  = in_valid_i && !w_full;
    w_done  = (r_state == WAIT_ACK) && (w_ack_s == r_req);
    // A completing transfer may immediately launch the next buffered word.
    w_pop   = !w_empty && ((r_state == IDLE) || w_done);
  end

  // Buffer storage write; contents need no reset because pointers gate validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[LOG_BUF_DEPTH-1:0]] <= in_data_i;
    end
  end

  // Buffer pointers; push and pop in the same cycle both advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Handshake FSM, output word register, transfer counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    assert (LOG_BUF_DEPTH >= 1) else $error("phase2_tx: LOG_BUF_DEPTH must be >= 1");
    assert (SYNC_STAGES >= 2) else $error("phase2_tx: SYNC_STAGES must be >= 2");
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_data <= r_mem[r_rptr[LOG_BUF_DEPTH-1:0]];
        r_req  <= ~r_req;
      end
      if (w_done) begin
        r_count <= r_count + 1'b1;
      end
      // An acknowledge toggle with nothing in flight is a protocol error.
      if ((r_state == IDLE) && (w_ack_s != r_req)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (w_done && !w_pop) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    in_ready_o = !w_full;
    req_o      = r_req;
    data_o     = r_data;
    idle_o     = (r_state == IDLE) && w_empty;
    err_o      = r_err;
    tx_count_o = r_count;
  end

endmodule

// File: doc/phase2_tx.md
PHASE2_TX -- requirements
Module: phase2_tx

Interface
REQ-001 Param T, default logic [31:0], payload type.
REQ-002 Param LOG_BUF_DEPTH, default 1, input buffer holds 2**LOG_BUF_DEPTH words; SHALL be >= 1 (sim assertion).
REQ-003 Param SYNC_STAGES, default 2, ack synchronizer depth; SHALL be >= 2 (sim assertion).
REQ-004 clk_i  input  1  sole clock; one clock, all flops on rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 in_data_i  input  $bits(T)  payload from local stream.
REQ-007 in_valid_i  input  1  payload valid.
REQ-008 in_ready_o  output  1  buffer can accept.
REQ-009 req_o  output  1  2-phase request; each toggle announces one word.
REQ-010 data_o  output  $bits(T)  word announced by req_o; registered.
REQ-011 ack_i  input  1  2-phase acknowledge toggle from remote receiver, asynchronous to clk_i.
REQ-012 idle_o  output  1  no buffered and no in-flight word.
REQ-013 err_o  output  1  sticky protocol-error flag.
REQ-014 tx_count_o  output  16  completed-transfer counter.

Function
REQ-015 Input accepted on a cycle with in_valid_i && in_ready_o; in_ready_o SHALL equal !buf_full, no dependence on in_valid_i, no pass-through when full.
REQ-016 Buffer is FIFO ordered; pointers LOG_BUF_DEPTH+1 bits, full when indices equal and MSBs differ, empty when all bits equal; pointers wrap modulo 2**(LOG_BUF_DEPTH+1).
REQ-017 ack_i SHALL pass through SYNC_STAGES flops before use (ack_s); no other logic on ack_i.
REQ-018 FSM states IDLE, WAIT_ACK; reset state IDLE.
REQ-019 IDLE, buffer non-empty: pop head into data_q, toggle req_q, go WAIT_ACK, all on the same edge.
REQ-020 Latency: word accepted into empty buffer at edge k in IDLE SHALL appear on data_o with req_o toggled at edge k+1.
REQ-021 WAIT_ACK, ack_s != req_q: hold; data_o and req_o SHALL not change.
REQ-022 WAIT_ACK, ack_s == req_q: transfer complete, tx_count_o += 1; if buffer non-empty, pop, load data_q, toggle req_q, stay WAIT_ACK on that edge; else go IDLE.
REQ-023 Simultaneous push and pop on a non-full buffer SHALL both take effect; occupancy unchanged.
REQ-024 tx_count_o wraps 16'hFFFF -> 16'h0000.
REQ-025 IDLE with ack_s != req_q (spurious ack toggle) SHALL set err_o on next edge; err_o holds until reset; FSM otherwise unaffected.
REQ-026 idle_o = (state == IDLE) && buffer empty, combinational from registers.
REQ-027 Max throughput: one word per (SYNC_STAGES + remote round-trip + 1) cycles; no word lost or duplicated.

Reset
REQ-028 Under rst_i: req_o=0, data_o='0, in_ready_o=1 after the reset edge, idle_o=1, err_o=0, tx_count_o=0, ack sync flops 0, buffer emptied, state IDLE.
REQ-029 Reset mid-operation SHALL discard buffered and in-flight words; remote receiver SHALL be reset in the same window so ack_i=0 when rst_i deasserts.
REQ-030 Buffer storage needs no reset; data_q SHALL be reset.

Structure
REQ-031 Package phase2_pkg SHALL hold the FSM state enum typedef and the counter width constant (16).
REQ-032 One sub-module phase2_sync: SYNC_STAGES-deep single-bit synchronizer, reset to 0 by rst_i; used for ack_i.
REQ-033 Buffer, FSM, counter inline in phase2_tx.

Verification
REQ-034 Single word: push 32'hCAFE_0001 in IDLE at edge k -> req_o 0->1 and data_o=32'hCAFE_0001 at k+1; bench toggles ack -> tx_count_o=1, idle_o=1 SYNC_STAGES+1 edges later.
REQ-035 Backpressure: depth 2, remote never acks, push 4 words -> word0 in flight, 2 buffered, in_ready_o=0; 4th held until first ack, then accepted in order.
REQ-036 Burst of 100 words, auto-responder acking after random 0-5 cycles -> received sequence identical, tx_count_o=100, err_o=0.
REQ-037 Spurious ack toggle while IDLE -> err_o=1 next-but-SYNC_STAGES edge, stays 1 until rst_i.
REQ-038 Counter wrap: preload via 65537 transfers -> tx_count_o=1.
REQ-039 rst_i asserted with 2 words buffered and one in flight -> after reset req_o=0, idle_o=1, no stale word emitted later.
